// File: rtl/sobel_pkg.sv
// Shared configuration for the Sobel front end: default frame geometry, the
// widths derived from it, and the pixel streamer's FSM state encoding.
package sobel_pkg;

  localparam int ROW_WIDTH  = 256;
  localparam int HEIGHT     = 256;
  localparam int DATA_WIDTH = 8;

  localparam int ADDR_W = $clog2(ROW_WIDTH * HEIGHT);
  localparam int ROW_W  = $clog2(HEIGHT);
  localparam int COL_W  = $clog2(ROW_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster position counter: walks (row, col) in scan order with wrap, flagging
// the first pixel, the end of each line and the last pixel of the frame.
module raster_counter
  import sobel_pkg::*;
#(
  parameter int ROW_WIDTH = sobel_pkg::ROW_WIDTH,
  parameter int HEIGHT    = sobel_pkg::HEIGHT
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_clr,
  input  logic                         i_adv,
  output logic [$clog2(HEIGHT)-1:0]    o_row,
  output logic [$clog2(ROW_WIDTH)-1:0] o_col,
  output logic                         o_first,
  output logic                         o_eol,
  output logic                         o_last
);

  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(ROW_WIDTH);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(ROW_WIDTH - 1);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_adv) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_row   = r_row;
  assign o_col   = r_col;
  assign o_first = (r_row == '0) && (r_col == '0);
  assign o_eol   = (r_col == COL_LAST);
  assign o_last  = (r_row == ROW_LAST) && (r_col == COL_LAST);

endmodule

// File: rtl/pixel_streamer.sv
// Frame-memory raster reader: issues one read per unpaused cycle and presents
// each returned pixel, with its position and frame/line markers, two edges later.
module pixel_streamer
  import sobel_pkg::*;
#(
  parameter int ROW_WIDTH  = sobel_pkg::ROW_WIDTH,
  parameter int HEIGHT     = sobel_pkg::HEIGHT,
  parameter int DATA_WIDTH = sobel_pkg::DATA_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  pause,
  output logic                                  mem_rd_en,
  output logic [$clog2(ROW_WIDTH*HEIGHT)-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata,
  output logic                                  recv_data,
  output logic [DATA_WIDTH-1:0]                 pixel,
  output logic [$clog2(HEIGHT)-1:0]             row,
  output logic [$clog2(ROW_WIDTH)-1:0]          col,
  output logic                                  frame_start,
  output logic                                  line_end,
  output logic                                  busy,
  output logic                                  done
);

  localparam int NPIX = ROW_WIDTH * HEIGHT;
  localparam int AW   = $clog2(NPIX);
  localparam int RW   = $clog2(HEIGHT);
  localparam int CW   = $clog2(ROW_WIDTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  state_t                r_state;
  logic [AW-1:0]         r_rd_addr;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_rd_vld_p0;
  logic                  r_recv_p1;
  logic                  r_fs_p1;
  logic                  r_le_p1;
  logic                  r_last_p1;
  logic [DATA_WIDTH-1:0] r_pixel_p1;
  logic [RW-1:0]         r_row_p1;
  logic [CW-1:0]         r_col_p1;

  logic                  w_rd_issue;
  logic                  w_pos_clr;
  logic [RW-1:0]         w_pos_row;
  logic [CW-1:0]         w_pos_col;
  logic                  w_pos_first;
  logic                  w_pos_eol;
  logic                  w_pos_last;

  assign w_rd_issue = (r_state == ST_STREAM) && !pause;
  assign w_pos_clr  = (r_state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_rd_addr <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_STREAM;
            r_busy    <= 1'b1;
            r_rd_addr <= '0;
          end
        end
        ST_STREAM: begin
          if (!pause) begin
            if (r_rd_addr == LAST_ADDR) begin
              r_rd_addr <= '0;
              r_state   <= ST_DRAIN;
            end else begin
              r_rd_addr <= r_rd_addr + 1'b1;
            end
          end
        end
        // The last pixel is on the output this cycle: finish on the next edge.
        ST_DRAIN: begin
          if (r_recv_p1 && r_last_p1) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // p0: read accepted by the memory; data returns during the following cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_vld_p0 <= 1'b0;
    end else begin
      r_rd_vld_p0 <= w_rd_issue;
    end
  end

  raster_counter #(
    .ROW_WIDTH(ROW_WIDTH),
    .HEIGHT   (HEIGHT)
  ) u_pos (
    .i_clk  (clk),
    .i_rst_n(rst),
    .i_clr  (w_pos_clr),
    .i_adv  (r_rd_vld_p0),
    .o_row  (w_pos_row),
    .o_col  (w_pos_col),
    .o_first(w_pos_first),
    .o_eol  (w_pos_eol),
    .o_last (w_pos_last)
  );

  // p1: returned pixel registered with its raster position; position holds between pixels
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_recv_p1  <= 1'b0;
      r_fs_p1    <= 1'b0;
      r_le_p1    <= 1'b0;
      r_last_p1  <= 1'b0;
      r_pixel_p1 <= '0;
      r_row_p1   <= '0;
      r_col_p1   <= '0;
    end else begin
      r_recv_p1 <= r_rd_vld_p0;
      r_fs_p1   <= r_rd_vld_p0 && w_pos_first;
      r_le_p1   <= r_rd_vld_p0 && w_pos_eol;
      if (r_rd_vld_p0) begin
        r_pixel_p1 <= mem_rdata;
        r_row_p1   <= w_pos_row;
        r_col_p1   <= w_pos_col;
        r_last_p1  <= w_pos_last;
      end
    end
  end

  assign mem_rd_en   = w_rd_issue;
  assign mem_addr    = r_rd_addr;
  assign recv_data   = r_recv_p1;
  assign pixel       = r_pixel_p1;
  assign row         = r_row_p1;
  assign col         = r_col_p1;
  assign frame_start = r_fs_p1;
  assign line_end    = r_le_p1;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_pixel_streamer.sv
// Bench for pixel_streamer on a 4x4 frame: random pixel memory and pause patterns
// checked against a read/latency/raster reference model.
module tb_pixel_streamer;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;
  localparam int DW = 8;
  localparam int AW = $clog2(N);
  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);
  localparam int MAXC = 96;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          recv_data;
  logic [DW-1:0] pixel;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          frame_start, line_end, busy, done;

  always #5 clk = ~clk;

  pixel_streamer #(.ROW_WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .recv_data(recv_data), .pixel(pixel), .row(row), .col(col),
    .frame_start(frame_start), .line_end(line_end), .busy(busy), .done(done)
  );

  logic [DW-1:0] mem [N];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int n_vec = 0;
  int n_err = 0;

  // captured trace, one entry per cycle
  int            ncyc;
  logic          t_rd [MAXC], t_recv [MAXC], t_fs [MAXC], t_le [MAXC];
  logic          t_busy [MAXC], t_done [MAXC], t_pause [MAXC];
  logic [AW-1:0] t_addr [MAXC];
  logic [DW-1:0] t_pix [MAXC];
  logic [RW-1:0] t_row [MAXC];
  logic [CW-1:0] t_col [MAXC];

  // reference model results
  logic e_rd [MAXC], e_recv [MAXC];
  int   e_addr [MAXC], e_idx [MAXC], e_pos [MAXC];
  int   e_last;

  task automatic sample(input int s);
    t_rd[s] = mem_rd_en;   t_addr[s] = mem_addr;  t_recv[s] = recv_data;
    t_pix[s] = pixel;      t_row[s] = row;        t_col[s] = col;
    t_fs[s] = frame_start; t_le[s] = line_end;    t_busy[s] = busy;
    t_done[s] = done;      t_pause[s] = pause;
  endtask

  // pmode: 0 no pause, 1 pause window [p0, p0+plen), 2 random pause
  task automatic run_frame(input int pmode, input int p0, input int plen,
                           input bit hold, input int ndone, output bit tmo);
    int seen = 0;
    int extra = 0;
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    @(negedge clk);
    start = 1'b1; pause = 1'b0;
    #1 sample(0);
    ncyc = 1;
    tmo = 1'b1;
    for (int s = 1; s < MAXC; s++) begin
      @(negedge clk);
      start = (seen >= ndone) ? 1'b0 : hold;
      case (pmode)
        1:       pause = (s >= p0) && (s < p0 + plen);
        2:       pause = ($urandom_range(0, 2) == 0);
        default: pause = 1'b0;
      endcase
      #1 sample(s);
      ncyc = s + 1;
      if (seen >= ndone) begin
        extra++;
        if (extra == 2) begin
          tmo = 1'b0;
          break;
        end
      end else if (done) begin
        seen++;
      end
    end
    start = 1'b0; pause = 1'b0;
  endtask

  // One read per unpaused streaming cycle, addresses 0..N-1 in order; each read
  // appears on the output two edges later; position holds between pixels.
  task automatic build_model();
    int k = 0;
    int j = 0;
    int pos = -1;
    e_last = -1;
    for (int s = 0; s < MAXC; s++) begin
      e_rd[s] = (s >= 1) && (k < N) && !t_pause[s];
      e_addr[s] = k;
      if (e_rd[s]) k++;
      e_recv[s] = (s >= 2) ? e_rd[s-2] : 1'b0;
      e_idx[s] = j;
      if (e_recv[s]) begin
        pos = j;
        j++;
        if (j == N) e_last = s;
      end
      e_pos[s] = pos;
    end
  endtask

  task automatic test_reset();
    logic [31:0] obs;
    rst = 1'b0; start = 1'b0; pause = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    obs = 32'({mem_rd_en, mem_addr, recv_data, pixel, row, col, frame_start, line_end, busy, done});
    n_vec++;
    if (obs !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs got=%0h exp=0", obs);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    bit tmo;
    run_frame(0, 0, 0, 1'b0, 1, tmo);
    n_vec++;
    if (tmo) begin n_err++; $display("FAIL basic_timeout got=no_done exp=done"); end
    build_model();
    for (int s = 0; s < ncyc; s++) begin
      n_vec++;
      if (t_rd[s] !== e_rd[s]) begin
        n_err++; $display("FAIL basic_rd_en s=%0d got=%0b exp=%0b", s, t_rd[s], e_rd[s]);
      end
      if (e_rd[s]) begin
        n_vec++;
        if (t_addr[s] !== AW'(e_addr[s])) begin
          n_err++; $display("FAIL basic_addr s=%0d got=%0d exp=%0d", s, t_addr[s], e_addr[s]);
        end
      end
      n_vec++;
      if (t_recv[s] !== e_recv[s]) begin
        n_err++; $display("FAIL basic_recv s=%0d got=%0b exp=%0b", s, t_recv[s], e_recv[s]);
      end
      if (e_recv[s]) begin
        n_vec++;
        if (t_pix[s] !== mem[e_idx[s]]) begin
          n_err++; $display("FAIL basic_pixel s=%0d got=%0h exp=%0h", s, t_pix[s], mem[e_idx[s]]);
        end
      end
      n_vec++;
      if (t_done[s] !== (s == e_last + 1)) begin
        n_err++; $display("FAIL basic_done s=%0d got=%0b exp=%0b", s, t_done[s], s == e_last + 1);
      end
      n_vec++;
      if (t_busy[s] !== (s >= 1 && s <= e_last)) begin
        n_err++; $display("FAIL basic_busy s=%0d got=%0b exp=%0b", s, t_busy[s], s >= 1 && s <= e_last);
      end
    end
  endtask

  task automatic test_pause();
    bit tmo;
    int first = -1;
    int last = -1;
    int npix = 0;
    int gaps = 0;
    run_frame(1, 6, 3, 1'b0, 1, tmo);
    n_vec++;
    if (tmo) begin n_err++; $display("FAIL pause_timeout got=no_done exp=done"); end
    build_model();
    for (int s = 0; s < ncyc; s++) begin
      n_vec++;
      if (t_recv[s] !== e_recv[s]) begin
        n_err++; $display("FAIL pause_recv s=%0d got=%0b exp=%0b", s, t_recv[s], e_recv[s]);
      end
      if (e_recv[s]) begin
        n_vec++;
        if (t_pix[s] !== mem[e_idx[s]]) begin
          n_err++; $display("FAIL pause_pixel s=%0d got=%0h exp=%0h", s, t_pix[s], mem[e_idx[s]]);
        end
      end
      if (e_pos[s] >= 0) begin
        n_vec++;
        if (t_row[s] !== RW'(e_pos[s] / W) || t_col[s] !== CW'(e_pos[s] % W)) begin
          n_err++; $display("FAIL pause_rowcol s=%0d got=%0d,%0d exp=%0d,%0d", s, t_row[s], t_col[s], e_pos[s] / W, e_pos[s] % W);
        end
      end
      if (t_recv[s]) begin
        npix++;
        if (first < 0) first = s;
        last = s;
      end
    end
    for (int s = first; s >= 0 && s <= last; s++) if (!t_recv[s]) gaps++;
    n_vec++;
    if (gaps !== 3) begin n_err++; $display("FAIL pause_gap_cycles got=%0d exp=3", gaps); end
    n_vec++;
    if (npix !== N) begin n_err++; $display("FAIL pause_pixel_count got=%0d exp=%0d", npix, N); end
  endtask

  task automatic test_markers();
    bit tmo;
    logic efs, ele;
    for (int f = 0; f < 2; f++) begin
      run_frame(2, 0, 0, 1'b0, 1, tmo);
      n_vec++;
      if (tmo) begin n_err++; $display("FAIL mark_timeout f=%0d got=no_done exp=done", f); end
      build_model();
      for (int s = 0; s < ncyc; s++) begin
        efs = e_recv[s] && (e_idx[s] == 0);
        ele = e_recv[s] && (e_idx[s] % W == W - 1);
        n_vec++;
        if (t_fs[s] !== efs) begin
          n_err++; $display("FAIL mark_frame_start f=%0d s=%0d got=%0b exp=%0b", f, s, t_fs[s], efs);
        end
        n_vec++;
        if (t_le[s] !== ele) begin
          n_err++; $display("FAIL mark_line_end f=%0d s=%0d got=%0b exp=%0b", f, s, t_le[s], ele);
        end
        n_vec++;
        if (e_pos[s] >= 0) begin
          if (t_row[s] !== RW'(e_pos[s] / W) || t_col[s] !== CW'(e_pos[s] % W)) begin
            n_err++; $display("FAIL mark_rowcol f=%0d s=%0d got=%0d,%0d exp=%0d,%0d", f, s, t_row[s], t_col[s], e_pos[s] / W, e_pos[s] % W);
          end
        end else if (t_row[s] !== RW'(H - 1) || t_col[s] !== CW'(W - 1)) begin
          n_err++; $display("FAIL mark_hold_prev_frame f=%0d s=%0d got=%0d,%0d exp=%0d,%0d", f, s, t_row[s], t_col[s], H - 1, W - 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit tmo;
    bit hit = 1'b0;
    int got = 0;
    int npix = 0;
    logic [31:0] obs;
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    @(negedge clk);
    start = 1'b1; pause = 1'b0;
    for (int s = 0; s < 40 && !hit; s++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (recv_data) got++;
      if (got == 8) hit = 1'b1;
    end
    n_vec++;
    if (!hit) begin n_err++; $display("FAIL rstmid_reach_pixel7 got=%0d exp=8", got); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    obs = 32'({mem_rd_en, mem_addr, recv_data, pixel, row, col, frame_start, line_end, busy, done});
    n_vec++;
    if (obs !== 32'd0) begin n_err++; $display("FAIL rstmid_outputs got=%0h exp=0", obs); end
    for (int s = 0; s < 24; s++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if ({done, recv_data, busy} !== 3'b000) begin
        n_err++; $display("FAIL rstmid_quiet s=%0d got=%b exp=000", s, {done, recv_data, busy});
      end
    end
    run_frame(0, 0, 0, 1'b0, 1, tmo);
    n_vec++;
    if (tmo) begin n_err++; $display("FAIL rstmid_refr_timeout got=no_done exp=done"); end
    build_model();
    for (int s = 0; s < ncyc; s++) begin
      n_vec++;
      if (t_recv[s] !== e_recv[s]) begin
        n_err++; $display("FAIL rstmid_recv s=%0d got=%0b exp=%0b", s, t_recv[s], e_recv[s]);
      end
      if (e_recv[s]) begin
        npix++;
        n_vec++;
        if (t_pix[s] !== mem[e_idx[s]] || t_row[s] !== RW'(e_idx[s] / W) || t_col[s] !== CW'(e_idx[s] % W)) begin
          n_err++; $display("FAIL rstmid_pixel s=%0d got=%0h@%0d,%0d exp=%0h@%0d,%0d", s, t_pix[s], t_row[s], t_col[s], mem[e_idx[s]], e_idx[s] / W, e_idx[s] % W);
        end
      end
      n_vec++;
      if (t_done[s] !== (s == e_last + 1)) begin
        n_err++; $display("FAIL rstmid_done s=%0d got=%0b exp=%0b", s, t_done[s], s == e_last + 1);
      end
    end
    n_vec++;
    if (npix !== N) begin n_err++; $display("FAIL rstmid_pixel_count got=%0d exp=%0d", npix, N); end
  endtask

  task automatic test_start_held();
    bit tmo;
    int d1;
    logic xrd, xrecv, xdone, xbusy;
    run_frame(0, 0, 0, 1'b1, 2, tmo);
    n_vec++;
    if (tmo) begin n_err++; $display("FAIL held_timeout got=no_second_done exp=done"); end
    build_model();
    d1 = e_last + 1;
    for (int s = 0; s < ncyc; s++) begin
      xrd   = e_rd[s]   || ((s > d1) ? e_rd[s-d1-1]   : 1'b0);
      xrecv = e_recv[s] || ((s > d1) ? e_recv[s-d1-1] : 1'b0);
      xdone = (s == d1) || (s == 2 * d1 + 1);
      xbusy = (s >= 1 && s <= d1 - 1) || (s >= d1 + 2 && s <= 2 * d1);
      n_vec++;
      if (t_rd[s] !== xrd) begin
        n_err++; $display("FAIL held_rd_en s=%0d got=%0b exp=%0b", s, t_rd[s], xrd);
      end
      n_vec++;
      if (t_recv[s] !== xrecv) begin
        n_err++; $display("FAIL held_recv s=%0d got=%0b exp=%0b", s, t_recv[s], xrecv);
      end
      n_vec++;
      if (t_done[s] !== xdone) begin
        n_err++; $display("FAIL held_done s=%0d got=%0b exp=%0b", s, t_done[s], xdone);
      end
      n_vec++;
      if (t_busy[s] !== xbusy) begin
        n_err++; $display("FAIL held_busy s=%0d got=%0b exp=%0b", s, t_busy[s], xbusy);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_markers();
    test_reset_mid();
    test_start_held();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_streamer.md
PIXEL_STREAMER -- requirements
Module: pixel_streamer

Interface
REQ-001 SHALL have parameter ROW_WIDTH, default 256, pixels per row.
REQ-002 SHALL have parameter HEIGHT, default 256, rows per frame.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, pixel bits.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  frame request, sampled in IDLE only.
REQ-007 SHALL have port pause  input  1  suppresses new memory reads while high.
REQ-008 SHALL have port mem_rd_en  output  1  frame-memory read strobe.
REQ-009 SHALL have port mem_addr  output  clog2(ROW_WIDTH*HEIGHT)  raster read address.
REQ-010 SHALL have port mem_rdata  input  DATA_WIDTH  read data, valid exactly one cycle after mem_rd_en.
REQ-011 SHALL have port recv_data  output  1  pixel valid strobe to the sobel_filter.
REQ-012 SHALL have port pixel  output  DATA_WIDTH  pixel value to the sobel_filter.
REQ-013 SHALL have port row  output  clog2(HEIGHT)  row index of the current output pixel.
REQ-014 SHALL have port col  output  clog2(ROW_WIDTH)  column index of the current output pixel.
REQ-015 SHALL have port frame_start  output  1  high with pixel (0,0).
REQ-016 SHALL have port line_end  output  1  high with col == ROW_WIDTH-1.
REQ-017 SHALL have port busy  output  1  frame in progress.
REQ-018 SHALL have port done  output  1  one-cycle frame-complete pulse.

Function
REQ-019 SHALL implement FSM states IDLE, STREAM, DRAIN, DONE.
REQ-020 IDLE: start high at edge E0 -> STREAM; busy high after E0; start SHALL be ignored in every other state.
REQ-021 STREAM: mem_rd_en = !pause (combinational); mem_addr = read counter, starting at 0, +1 per issued read.
REQ-022 Read issued in cycle E0..E1 SHALL have its data registered onto pixel at E2, with recv_data high for E2..E3 (two-edge latency, read to output).
REQ-023 pause high in a cycle SHALL suppress that cycle's read only; the in-flight read SHALL still be output; recv_data low exactly one cycle per paused read cycle.
REQ-024 When the read for address ROW_WIDTH*HEIGHT-1 issues -> DRAIN; pause ignored in DRAIN.
REQ-025 DRAIN: after the last pixel's recv_data cycle -> DONE; done high for one cycle, busy low in that same cycle; then -> IDLE.
REQ-026 row/col SHALL track the output pixel, raster order: col wraps ROW_WIDTH-1 -> 0 with row +1; row and col SHALL hold while recv_data is low.
REQ-027 frame_start and line_end SHALL be asserted only while recv_data is high.
REQ-028 Each frame SHALL deliver exactly ROW_WIDTH*HEIGHT pixels, with no duplicates or drops.
REQ-029 With pause low, recv_data SHALL be high for ROW_WIDTH*HEIGHT consecutive cycles.
REQ-030 start high during DONE SHALL be ignored; a new frame requires start sampled in IDLE.

Reset
REQ-031 rst low at an edge SHALL force IDLE; counters, row and col SHALL go to 0.
REQ-032 rst low SHALL force recv_data, pixel, mem_rd_en, frame_start, line_end, busy and done to 0; mem_addr to 0.
REQ-033 Reset mid-frame SHALL abort it with no done pulse; an in-flight read SHALL be discarded.

Structure
REQ-034 sobel_pkg SHALL hold ROW_WIDTH, HEIGHT, DATA_WIDTH, the derived address/row/col widths, and the FSM state enum.
REQ-035 A sub-module raster_counter (row/col with wrap and a last flag) SHALL be used for the output-side position tracking.

Verification (ROW_WIDTH=4, HEIGHT=4 unless stated)
REQ-036 start pulse, pause low -> mem_addr 0..15 on 16 consecutive cycles; recv_data high 16 consecutive cycles, starting 2 edges after the first read; pixel == mem[addr]; done one cycle after the last pixel.
REQ-037 pause high for 3 cycles mid-frame -> exactly 3 recv_data-low cycles; 16 pixels total, in order; row/col hold during the gap.
REQ-038 Marker check -> frame_start only at (0,0); line_end at col 3 of rows 0..3; row goes 3 -> 0 and col goes 3 -> 0 only on the next frame.
REQ-039 rst low at pixel 7 -> all outputs 0 next cycle with no done; a subsequent start gives a full, clean 16-pixel frame.
REQ-040 start held high through STREAM and DONE -> exactly one frame, then a second frame beginning after IDLE is entered.
REQ-041 Default 256x256 with a loopback into sobel_filter -> 65536 recv_data pulses, and the last output is at row 255, col 255.
